// File: rtl/contador_m_redux_multi_pkg.sv
// contador_m_redux_multi_pkg: modo encodings, divider width and parameter legality for the redux counter
package contador_m_redux_multi_pkg;
  localparam logic [1:0] MODO_WRAP = 2'b00;
  localparam logic [1:0] MODO_SAT = 2'b01;
  localparam logic [1:0] MODO_BOUNCE = 2'b10;
  function automatic int div_w(input int n, input int score_n);
    return n + score_n;
  endfunction
  function automatic bit params_ok(input int m, input int n, input int score_n, input int min_m, input int nch);
    return n >= 1 && score_n >= 1 && nch >= 1 && min_m >= 1 && min_m <= m && m <= (1 << n) - 1;
  endfunction
endpackage

// File: rtl/contador_m_redux_multi_if.sv
// contador_m_redux_multi_if: channel controls, difficulty score and counter status bundle
interface contador_m_redux_multi_if #(
  parameter int N = 7,
  parameter int SCORE_N = 8,
  parameter int NCH = 4
);
  logic [NCH-1:0] zera_s, conta, count_up;
  logic [1:0] modo;
  logic [SCORE_N-1:0] score;
  logic [NCH*N-1:0] Q;
  logic [NCH-1:0] fim, inicio, dir;
  logic [N-1:0] M_eff_out, mid_idx_out, max_idx_out;
  logic busy, upd;
  modport master (
    output zera_s, conta, count_up, modo, score,
    input Q, fim, inicio, dir, M_eff_out, mid_idx_out, max_idx_out, busy, upd
  );
  modport slave (
    input zera_s, conta, count_up, modo, score,
    output Q, fim, inicio, dir, M_eff_out, mid_idx_out, max_idx_out, busy, upd
  );
endinterface

// File: rtl/redux_div_seq.sv
// redux_div_seq: restoring divider, one quotient bit per cycle; done marks the last busy cycle
module redux_div_seq #(
  parameter int W = 15,
  parameter int QW = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic busy,
  output logic done,
  output logic [QW-1:0] quotient
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] rem, q;
  logic [CW-1:0] cnt;
  logic [W:0] trial;
  // borrow out of the trial subtraction means the shifted remainder was below the divisor
  assign trial = {rem, q[W-1]} - {1'b0, divisor};
  assign done = busy && cnt == '0;
  assign quotient = q[QW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      rem <= '0;
      q <= dividend;
      cnt <= CW'(W);
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      rem <= trial[W] ? {rem[W-2:0], q[W-1]} : trial[W-1:0];
      q <= {q[W-2:0], ~trial[W]};
    end
endmodule

// File: rtl/contador_m_redux_multi.sv
// contador_m_redux_multi: NCH counters sharing a modulus shrunk by a difficulty score
// through a sequential divider; new limits land on the upd edge with clamping.
module contador_m_redux_multi
  import contador_m_redux_multi_pkg::*;
#(
  parameter int M = 100,
  parameter int N = 7,
  parameter int SCORE_N = 8,
  parameter int MIN_M = 10,
  parameter int NCH = 4
) (
  input logic clock,
  input logic zera_as_n,
  contador_m_redux_multi_if.slave bus
);
  localparam int W = div_w(N, SCORE_N);
  localparam logic [W-1:0] DIFF = W'(M - MIN_M);
  localparam logic [W-1:0] DEN = W'((1 << SCORE_N) - 1);
  if (!params_ok(M, N, SCORE_N, MIN_M, NCH)) begin : g_bad_params
    $error("contador_m_redux_multi: illegal parameter set");
  end
  logic [SCORE_N-1:0] last;
  logic [N-1:0] m_eff, quot, nm_eff, nmax, mid, mx;
  logic start, dbusy, done;
  assign start = !dbusy && bus.score != last;
  redux_div_seq #(.W(W), .QW(N)) u_div (
    .clk(clock),
    .rst_n(zera_as_n),
    .start(start),
    .dividend(DIFF * W'(bus.score)),
    .divisor(DEN),
    .busy(dbusy),
    .done(done),
    .quotient(quot)
  );
  always_ff @(posedge clock or negedge zera_as_n)
    if (!zera_as_n) begin
      last <= '0;
      m_eff <= N'(M);
    end else begin
      if (start) last <= bus.score;
      if (done) m_eff <= nm_eff;
    end
  // counting on the upd edge already uses the limits being applied there
  assign nm_eff = done ? N'(M) - quot : m_eff;
  assign nmax = nm_eff - N'(1);
  assign mid = m_eff >> 1;
  assign mx = m_eff - N'(1);
  assign bus.M_eff_out = m_eff;
  assign bus.mid_idx_out = mid;
  assign bus.max_idx_out = mx;
  assign bus.busy = dbusy;
  assign bus.upd = done;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [N-1:0] q, qn;
    logic d, dn, up, bounce, sat;
    assign bounce = bus.modo == MODO_BOUNCE;
    assign sat = bus.modo == MODO_SAT;
    assign up = bounce ? d : bus.count_up[i];
    always_comb begin
      qn = q;
      dn = d;
      if (bus.zera_s[i]) begin
        qn = mid;
        dn = bus.count_up[i];
      end else if (done && q > nmax) begin
        qn = nmax;
      end else if (bus.conta[i]) begin
        if (nmax == '0) qn = '0;
        else if (bounce && d && q >= nmax) begin
          qn = nmax - N'(1);
          dn = 1'b0;
        end else if (bounce && !d && q == '0) begin
          qn = N'(1);
          dn = 1'b1;
        end else if (up) qn = q >= nmax ? (sat ? nmax : '0) : q + N'(1);
        else qn = q == '0 ? (sat ? '0 : nmax) : q - N'(1);
      end
    end
    always_ff @(posedge clock or negedge zera_as_n)
      if (!zera_as_n) begin
        q <= N'(M / 2);
        d <= 1'b1;
      end else begin
        q <= qn;
        d <= dn;
      end
    assign bus.Q[i*N +: N] = q;
    assign bus.fim[i] = q == mx;
    assign bus.inicio[i] = q == '0;
    assign bus.dir[i] = up;
  end
endmodule

// File: tb/tb_contador_m_redux_multi.sv
// tb_contador_m_redux_multi: directed and random stimulus; a reference model pushes expected
// status per edge into a queue that a monitor pops and compares after each rising edge.
module tb_contador_m_redux_multi;
  localparam int M = 100, N = 7, SN = 8, MIN_M = 10, NCH = 4, DIV_W = N + SN;
  typedef struct {
    logic [NCH*N-1:0] q;
    logic [NCH-1:0] fim, ini, dir;
    logic [3*N-1:0] lim;
    logic busy, upd;
  } exp_t;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  exp_t expq[$];
  int m_q[NCH];
  bit m_d[NCH];
  int m_meff, m_last, m_timer, m_pend;
  int cur_md = 0, cur_sc = 0;
  contador_m_redux_multi_if #(.N(N), .SCORE_N(SN), .NCH(NCH)) bus ();
  contador_m_redux_multi #(.M(M), .N(N), .SCORE_N(SN), .MIN_M(MIN_M), .NCH(NCH)) dut (
    .clock(clk),
    .zera_as_n(rst_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
  task automatic model_reset();
    m_meff = M;
    m_last = 0;
    m_timer = 0;
    for (int i = 0; i < NCH; i++) begin
      m_q[i] = M / 2;
      m_d[i] = 1'b1;
    end
  endtask
  // one clock edge of the behavioural model with the given inputs
  task automatic model_edge(input logic [NCH-1:0] z, input logic [NCH-1:0] c, input logic [NCH-1:0] u, input int md, input int sc);
    bit ue;
    int nm;
    ue = m_timer == 1;
    nm = ue ? m_pend : m_meff;
    for (int i = 0; i < NCH; i++) begin
      int p;
      if (z[i]) begin
        m_q[i] = m_meff / 2;
        m_d[i] = u[i];
      end else if (ue && m_q[i] > nm - 1) m_q[i] = nm - 1;
      else if (c[i]) begin
        if (nm == 1) m_q[i] = 0;
        else if (md == 2) begin
          p = m_q[i] + (m_d[i] ? 1 : -1);
          if (p > nm - 1) begin
            m_q[i] = nm - 2;
            m_d[i] = 1'b0;
          end else if (p < 0) begin
            m_q[i] = 1;
            m_d[i] = 1'b1;
          end else m_q[i] = p;
        end else if (md == 1) m_q[i] = u[i] ? (m_q[i] + 1 > nm - 1 ? nm - 1 : m_q[i] + 1) : (m_q[i] == 0 ? 0 : m_q[i] - 1);
        else m_q[i] = u[i] ? (m_q[i] + 1) % nm : (m_q[i] + nm - 1) % nm;
      end
    end
    if (m_timer == 0 && sc != m_last) begin
      m_last = sc;
      m_pend = M - ((M - MIN_M) * sc) / ((1 << SN) - 1);
      m_timer = DIV_W + 1;
    end else if (m_timer > 0) m_timer--;
    m_meff = nm;
  endtask
  task automatic push_exp(input logic [NCH-1:0] u, input int md);
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e.q[i*N +: N] = N'(m_q[i]);
      e.fim[i] = m_q[i] == m_meff - 1;
      e.ini[i] = m_q[i] == 0;
      e.dir[i] = md == 2 ? m_d[i] : u[i];
    end
    e.lim = {N'(m_meff), N'(m_meff / 2), N'(m_meff - 1)};
    e.busy = m_timer > 0;
    e.upd = m_timer == 1;
    expq.push_back(e);
  endtask
  task automatic step(input logic [NCH-1:0] z, input logic [NCH-1:0] c, input logic [NCH-1:0] u, input int md, input int sc);
    @(negedge clk);
    rst_n = 1'b1;
    bus.zera_s = z;
    bus.conta = c;
    bus.count_up = u;
    bus.modo = 2'(md);
    bus.score = SN'(sc);
    cur_md = md;
    cur_sc = sc;
    model_edge(z, c, u, md, sc);
    push_exp(u, md);
  endtask
  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.zera_s = '0;
      bus.conta = '0;
      bus.count_up = '0;
      bus.modo = 2'b00;
      model_reset();
      push_exp('0, 0);
    end
  endtask
  task automatic idle(input int n, input int md, input int sc);
    repeat (n) step('0, '0, '0, md, sc);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks += 5;
        if (bus.Q !== e.q) begin
          errors++;
          $display("FAIL Q t=%0t got %h want %h", $time, bus.Q, e.q);
        end
        if ({bus.fim, bus.inicio} !== {e.fim, e.ini}) begin
          errors++;
          $display("FAIL fim_inicio t=%0t got %b_%b want %b_%b", $time, bus.fim, bus.inicio, e.fim, e.ini);
        end
        if (bus.dir !== e.dir) begin
          errors++;
          $display("FAIL dir t=%0t got %b want %b", $time, bus.dir, e.dir);
        end
        if ({bus.M_eff_out, bus.mid_idx_out, bus.max_idx_out} !== e.lim) begin
          errors++;
          $display("FAIL limits t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time, bus.M_eff_out, bus.mid_idx_out,
                   bus.max_idx_out, e.lim[3*N-1 -: N], e.lim[2*N-1 -: N], e.lim[N-1:0]);
        end
        if ({bus.busy, bus.upd} !== {e.busy, e.upd}) begin
          errors++;
          $display("FAIL busy_upd t=%0t got %b%b want %b%b", $time, bus.busy, bus.upd, e.busy, e.upd);
        end
      end
    end
  end
  initial begin
    logic [NCH-1:0] z, c, u;
    int guard;
    rst_n = 1'b0;
    bus.zera_s = '0;
    bus.conta = '0;
    bus.count_up = '0;
    bus.modo = 2'b00;
    bus.score = '0;
    hold_reset(2);
    idle(4, 0, 0);
    idle(20, 0, 255);
    idle(5, 0, 128);
    idle(40, 0, 255);
    step(4'b0000, 4'b0001, 4'b0001, 0, 255);
    step(4'b0010, 4'b0000, 4'b0000, 0, 255);
    repeat (6) step(4'b0000, 4'b0010, 4'b0000, 0, 255);
    repeat (9) step(4'b0000, 4'b0001, 4'b0001, 0, 255);
    step(4'b0000, 4'b0001, 4'b0001, 1, 255);
    step(4'b0000, 4'b0010, 4'b0000, 1, 255);
    step(4'b0100, 4'b0000, 4'b0100, 2, 255);
    repeat (5) step(4'b0000, 4'b0100, 4'b0000, 2, 255);
    repeat (9) step(4'b0000, 4'b0100, 4'b0100, 2, 255);
    step(4'b0100, 4'b0000, 4'b0000, 2, 255);
    step(4'b0000, 4'b0000, 4'b1111, 0, 255);
    idle(20, 0, 0);
    step(4'b0010, 4'b0000, 4'b0000, 0, 0);
    guard = 0;
    step(4'b0000, 4'b0000, 4'b0000, 0, 255);
    while (m_timer != 1 && guard < 100) begin
      step('0, '0, '0, 0, 255);
      guard++;
    end
    step(4'b0001, 4'b1111, 4'b1010, 0, 255);
    step(4'b0001, 4'b0000, 4'b0001, 0, 255);
    idle(5, 0, 128);
    hold_reset(2);
    idle(4, 0, 0);
    idle(20, 0, 128);
    for (int k = 0; k < 3000; k++) begin
      int md, sc;
      md = cur_md;
      sc = cur_sc;
      if ($urandom_range(0, 39) == 0) sc = $urandom_range(0, 255);
      if ($urandom_range(0, 49) == 0) md = $urandom_range(0, 3);
      z = '0;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 15) == 0) z[i] = 1'b1;
      if (m_timer == 1) z = '0;
      c = NCH'($urandom);
      u = NCH'($urandom);
      step(z, c, u, md, sc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
